// File: rtl/dual_port_read_sequencer_if.sv
// Bus bundle for dual_port_read_sequencer: sweep control, the two SRAM read
// ports and the paired-word output handshake.
// num_words carries one bit more than an address so that the full 2*DEPTH
// span and out-of-range lengths (e.g. 2*DEPTH+1) can both be expressed.
interface dual_port_read_sequencer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 12
);
    logic                  start;
    logic [ADDR_WIDTH:0]   num_words;
    logic                  abort;
    logic                  ren;
    logic [ADDR_WIDTH-1:0] radr;
    logic                  rwen;
    logic [ADDR_WIDTH-1:0] rwadr;
    logic [DATA_WIDTH-1:0] rdata;
    logic [DATA_WIDTH-1:0] rwdata;
    logic [DATA_WIDTH-1:0] out_a;
    logic [DATA_WIDTH-1:0] out_b;
    logic                  out_valid;
    logic                  out_ready;
    logic                  busy;
    logic                  done;

    // Sequencer side.
    modport master (
        input  start, num_words, abort, rdata, rwdata, out_ready,
        output ren, radr, rwen, rwadr, out_a, out_b, out_valid, busy, done
    );

    // Environment side (SRAM plus output consumer).
    modport slave (
        output start, num_words, abort, rdata, rwdata, out_ready,
        input  ren, radr, rwen, rwadr, out_a, out_b, out_valid, busy, done
    );
endinterface

// File: rtl/dual_port_read_sequencer.sv
// dual_port_read_sequencer: sweeps indices 0..N-1, reading word i on the
// read-only port and word N-1-i on the read/write port, and streams the pairs
// through a 2-entry FIFO with a valid/ready handshake.
// Build option: define SEQ_DUAL_PORT_EN for dual-port operation; without it
// the read/write port is unused (rwen/rwadr/out_b tied low) and timing is
// identical.
module dual_port_read_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 12,
    parameter int DEPTH      = 2048
) (
    input  logic                       clk,
    input  logic                       rst_n,
    dual_port_read_sequencer_if.master bus
);
    // Index arithmetic is one bit wider than an address so N = 2*DEPTH works.
    localparam int              CW        = ADDR_WIDTH + 1;
    localparam logic [CW-1:0]   MAX_WORDS = CW'(2 * DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         len_q, len_d;
    logic [CW-1:0]         idx_q, idx_d;
    logic                  inflight_q;
    logic [1:0]            count_q, count_d;
    logic                  wr_ptr_q, rd_ptr_q;
    logic [DATA_WIDTH-1:0] fifo_a_q [2];
    logic                  bad_start_q;

    logic                  len_ok, start_ok, flush, pop, push, issue;
    logic [2:0]            occ;

    assign len_ok   = (bus.num_words != '0) && (bus.num_words <= MAX_WORDS);
    // abort beats start in IDLE: nothing launches and no done pulse follows
    assign start_ok = (state_q == IDLE) && bus.start && !bus.abort;
    assign flush    = bus.abort && (state_q != IDLE);
    assign pop      = (count_q != 2'd0) && bus.out_ready;
    assign push     = inflight_q;
    // Words that will occupy the FIFO next cycle if nothing new is issued;
    // keeping it below 2 leaves room for the read issued now.
    assign occ      = 3'(count_q) + 3'(inflight_q) - 3'(pop);
    assign issue    = (state_q == RUN) && !bus.abort && (occ < 3'd2);
    assign count_d  = count_q + {1'b0, push} - {1'b0, pop};

    // Next-state logic for the sweep controller.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (start_ok && len_ok) begin
                    state_d = RUN;
                    len_d   = bus.num_words;
                    idx_d   = '0;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_d = DONE;
                end else if (issue) begin
                    idx_d = idx_q + 1'b1;
                    if (idx_q == len_q - 1'b1) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // leave once the last word has been handed off
                if (bus.abort || (occ == 3'd0)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Controller state, sweep length and index registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
        end
    end

    // A rejected start (length 0 or beyond the span) still gets a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bad_start_q <= 1'b0;
        end else begin
            bad_start_q <= start_ok && !len_ok;
        end
    end

    // In-flight tracking and FIFO pointers/count; abort drops everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= 1'b0;
            count_q    <= 2'd0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
        end else if (flush) begin
            inflight_q <= 1'b0;
            count_q    <= 2'd0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
        end else begin
            inflight_q <= issue;
            count_q    <= count_d;
            if (push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    // Capture read-only port data one cycle after its request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_a_q[0] <= '0;
            fifo_a_q[1] <= '0;
        end else if (push && !flush) begin
            fifo_a_q[wr_ptr_q] <= bus.rdata;
        end
    end

    assign bus.ren       = issue;
    assign bus.radr      = issue ? idx_q[ADDR_WIDTH-1:0] : '0;
    assign bus.out_a     = fifo_a_q[rd_ptr_q];
    assign bus.out_valid = (count_q != 2'd0);
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE) || bad_start_q;

`ifdef SEQ_DUAL_PORT_EN
    logic [DATA_WIDTH-1:0] fifo_b_q [2];

    // Capture read/write port data alongside its read-only partner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_b_q[0] <= '0;
            fifo_b_q[1] <= '0;
        end else if (push && !flush) begin
            fifo_b_q[wr_ptr_q] <= bus.rwdata;
        end
    end

    assign bus.rwen  = issue;
    // mirrored index N-1-i; always in range for legal N
    assign bus.rwadr = issue ? ADDR_WIDTH'(len_q - idx_q - 1'b1) : '0;
    assign bus.out_b = fifo_b_q[rd_ptr_q];
`else
    logic unused_rwdata;

    assign unused_rwdata = ^bus.rwdata;
    assign bus.rwen      = 1'b0;
    assign bus.rwadr     = '0;
    assign bus.out_b     = '0;
`endif

endmodule

// File: tb/tb_dual_port_read_sequencer.sv
// Scoreboard bench for dual_port_read_sequencer. Expected pairs are queued
// when a sweep is launched; a negedge monitor pops and compares on every
// output handshake and checks issue addresses and back-pressure.
// Expectations follow SEQ_DUAL_PORT_EN the same way the design does.
module tb_dual_port_read_sequencer;
    localparam int DW = 16;
    localparam int AW = 12;
    localparam int DEPTH = 2048;

    typedef struct packed {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } pair_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dual_port_read_sequencer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    dual_port_read_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [DW-1:0] mem [0:4095];
    pair_t sbq [$];
    int errors = 0;
    int checks = 0;
    int sweep_n = 0;
    int exp_idx = 0;
    int outstanding = 0;
    int rdy_mode = 0;
    int rdy_cnt = 0;
    bit prev_stall = 1'b0;
    logic [DW-1:0] prev_a, prev_b;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // SRAM model: one-cycle read latency on both ports.
    always @(posedge clk) begin
        if (bus.ren)  bus.rdata  <= mem[bus.radr];
        if (bus.rwen) bus.rwdata <= mem[bus.rwadr];
    end

    // Output consumer: always ready, or ready on every third cycle.
    always @(posedge clk) begin
        #1;
        if (rdy_mode == 0) begin
            bus.out_ready = 1'b1;
        end else begin
            bus.out_ready = (rdy_cnt % 3 == 0);
            rdy_cnt++;
        end
    end

    // Monitor: scoreboard pops, stall stability, issue addresses and room.
    always @(negedge clk) begin
        pair_t e;
        bit pop;
        if (!rst_n) begin
            sbq.delete();
            outstanding = 0;
            prev_stall = 1'b0;
        end else begin
            pop = bus.out_valid && bus.out_ready;
            if (prev_stall) begin
                chk("stall_valid", 32'(bus.out_valid), 1);
                chk("stall_a", 32'(bus.out_a), 32'(prev_a));
                chk("stall_b", 32'(bus.out_b), 32'(prev_b));
            end
            if (pop) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_pop", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("pair_a", 32'(bus.out_a), 32'(e.a));
                    chk("pair_b", 32'(bus.out_b), 32'(e.b));
                end
            end
            if (bus.ren) begin
                chk("ren_room", 32'((outstanding - int'(pop)) < 2), 1);
                chk("ren_in_range", 32'(exp_idx < sweep_n), 1);
                chk("radr", 32'(bus.radr), 32'(exp_idx));
`ifdef SEQ_DUAL_PORT_EN
                chk("rwadr", 32'(bus.rwadr), 32'(sweep_n - 1 - exp_idx));
`else
                chk("rwadr", 32'(bus.rwadr), 0);
`endif
                exp_idx++;
            end else begin
                chk("noissue_addr", 32'({bus.radr, bus.rwadr}), 0);
            end
`ifdef SEQ_DUAL_PORT_EN
            chk("rwen_pair", 32'(bus.rwen), 32'(bus.ren));
`else
            chk("rwen_zero", 32'(bus.rwen), 0);
`endif
            outstanding = outstanding + int'(bus.ren) - int'(pop);
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_a = bus.out_a;
            prev_b = bus.out_b;
            if (bus.abort && bus.busy) begin
                sbq.delete();
                outstanding = 0;
                prev_stall = 1'b0;
            end
        end
    end

    task automatic chk_reset(input string tag);
        chk({tag, "_ren"}, 32'({bus.ren, bus.rwen}), 0);
        chk({tag, "_adr"}, 32'({bus.radr, bus.rwadr}), 0);
        chk({tag, "_out"}, {bus.out_a, bus.out_b}, 0);
        chk({tag, "_flags"}, 32'({bus.out_valid, bus.busy, bus.done}), 0);
    endtask

    // Queue expectations and pulse start; returns just after the accepting edge.
    task automatic launch(input int n, input int mode);
        pair_t p;
        rdy_mode = mode;
        for (int i = 0; i < n; i++) begin
            p.a = mem[i];
`ifdef SEQ_DUAL_PORT_EN
            p.b = mem[n - 1 - i];
`else
            p.b = '0;
`endif
            sbq.push_back(p);
        end
        sweep_n = n;
        exp_idx = 0;
        bus.num_words = 13'(n);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    // Wait (bounded) for done; lat < 0 skips the latency checks.
    task automatic wait_done(input int lat, input string tag);
        int cyc;
        int first;
        bit got;
        cyc = 0;
        first = -1;
        got = 1'b0;
        while (!got && cyc < 20000) begin
            @(negedge clk);
            if (bus.out_valid && first < 0) first = cyc;
            if (bus.done) got = 1'b1;
            else begin
                @(posedge clk);
                #1 cyc++;
            end
        end
        chk({tag, "_done_seen"}, 32'(got), 1);
        if (lat >= 0) begin
            chk({tag, "_done_lat"}, cyc, lat);
            chk({tag, "_first_valid"}, first, 2);
        end
        @(negedge clk);
        chk({tag, "_done_once"}, 32'(bus.done), 0);
        chk({tag, "_idle"}, 32'(bus.busy), 0);
        chk({tag, "_drained"}, sbq.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic bad_start(input int n, input string tag);
        sweep_n = 0;
        exp_idx = 0;
        bus.num_words = 13'(n);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        chk({tag, "_done"}, 32'({bus.done, bus.busy}), 32'(2'b10));
        @(negedge clk);
        chk({tag, "_after"}, 32'({bus.done, bus.busy}), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.num_words = '0;
        for (int k = 0; k < 4096; k++) mem[k] = 16'(k) ^ 16'hA5A5;
        #2 chk_reset("por");
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // full span, always ready
        launch(4096, 0);
        wait_done(4098, "n4096");

        // single word: both ports read address 0
        launch(1, 0);
        wait_done(3, "n1");

        // back-pressure
        launch(8, 1);
        wait_done(-1, "n8_stall");

        // abort on the 5th cycle of a long sweep
        launch(100, 0);
        repeat (4) @(posedge clk);
        #1 bus.abort = 1'b1;
        @(posedge clk);
        #1 bus.abort = 1'b0;
        @(negedge clk);
        chk("abort_state", 32'({bus.out_valid, bus.done, bus.busy}), 32'(3'b011));
        @(negedge clk);
        chk("abort_after", 32'({bus.out_valid, bus.done, bus.busy}), 0);
        @(posedge clk);
        #1;
        launch(3, 0);
        wait_done(5, "n3_after_abort");

        // illegal lengths
        bad_start(0, "len0");
        bad_start(4097, "len4097");

        // abort and start together while idle
        sweep_n = 0;
        bus.num_words = 13'(5);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        bus.abort = 1'b0;
        @(negedge clk);
        chk("abort_start_idle", 32'({bus.done, bus.busy}), 0);
        @(negedge clk);
        chk("abort_start_idle2", 32'({bus.done, bus.busy, bus.ren}), 0);
        @(posedge clk);
        #1;

        launch(16, 0);
        wait_done(18, "n16");

        // reset mid-sweep, then start on the first edge after release
        launch(20, 0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk_reset("midrst");
        @(negedge clk);
        chk("midrst_nodone", 32'(bus.done), 0);
        #1 rst_n = 1'b1;
        launch(2, 0);
        wait_done(4, "n2_post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end
endmodule
